sobel_frame_sequencer: RTL and testbench

Parametrised frame-level sequencer for the Sobel pipeline (buffer → shifter → hold → mult → mag/dir → out blocks). It replaces the fixed-count enable schedule with a slot-based scheduler. The scheduler generates SRAM1 read addresses and per-stage one-cycle enables for any image size, lane width and row-skip mode. It adds output back-pressure, abort, pipeline drain, a programmable prefetch request (get_next) and a frame-done handshake.

---
 rtl/sobel_pkg.sv | 43 ++++
 rtl/sobel_slot_timer.sv | 48 ++++
 rtl/sobel_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel pipeline blocks.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int SOBEL_IMG_W        = 512;
  localparam int SOBEL_IMG_H        = 512;
  localparam int SOBEL_PIX_PER_WORD = 8;
  localparam int SOBEL_WORD_W       = 64;
  localparam int SOBEL_ADDR_W       = 20;
  localparam int SOBEL_SLOT_LEN     = 8;

  localparam int SOBEL_PH_POP   = 0;
  localparam int SOBEL_PH_SHIFT = 2;
  localparam int SOBEL_PH_HOLD  = 3;
  localparam int SOBEL_PH_MULT  = 4;
  localparam int SOBEL_PH_MAG   = 5;
  localparam int SOBEL_PH_OUT   = 6;

  // True when all six stage phases are distinct and inside the slot.
  function automatic bit phases_ok(input int p0, input int p1, input int p2,
                                   input int p3, input int p4, input int p5,
                                   input int slot_len);
    int p [6];
    bit ok;
    ok = 1'b1;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3; p[4] = p4; p[5] = p5;
    for (int i = 0; i < 6; i++) begin
      if (p[i] < 0 || p[i] >= slot_len) ok = 1'b0;
      for (int j = i + 1; j < 6; j++) begin
        if (p[i] == p[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/sobel_slot_timer.sv
// Slot phase counter with stall freeze and a saturating completed-slot count.
module sobel_slot_timer
  import sobel_pkg::*;
#(
  parameter int SLOT_LEN = SOBEL_SLOT_LEN,
  parameter int PH_W     = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [PH_W-1:0]  phase_o,
  output logic [CNT_W-1:0] slot_cnt_o
);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_end;

  assign slot_end = (phase_q == PH_W'(SLOT_LEN - 1));

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      phase_d = '0;
      cnt_d   = '0;
    end else if (step_i) begin
      phase_d = slot_end ? '0 : phase_q + PH_W'(1);
      if (slot_end && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_o    = phase_q;
  assign slot_cnt_o = cnt_q;

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer: slot-based stage enables, SRAM1 read addressing, prefetch and frame handshake.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W        = SOBEL_IMG_W,
  parameter int IMG_H        = SOBEL_IMG_H,
  parameter int PIX_PER_WORD = SOBEL_PIX_PER_WORD,
  parameter int ADDR_W       = SOBEL_ADDR_W,
  parameter int SLOT_LEN     = SOBEL_SLOT_LEN,
  parameter int PH_POP       = SOBEL_PH_POP,
  parameter int PH_SHIFT     = SOBEL_PH_SHIFT,
  parameter int PH_HOLD      = SOBEL_PH_HOLD,
  parameter int PH_MULT      = SOBEL_PH_MULT,
  parameter int PH_MAG       = SOBEL_PH_MAG,
  parameter int PH_OUT       = SOBEL_PH_OUT,
  parameter int FILL_SLOTS   = 2,
  parameter int DRAIN_SLOTS  = 2,
  parameter int PREFETCH_ROW = 410,
  localparam int WPR   = IMG_W / PIX_PER_WORD,
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_en_i,
  input  logic              skip_rows_i,
  input  logic              out_ready_i,
  input  logic              abort_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              pop_en_o,
  output logic              shift_en_o,
  output logic              hold_en_o,
  output logic              mult_en_o,
  output logic              magdir_en_o,
  output logic              out_en_o,
  output logic              get_next_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [ROW_W-1:0]  row_idx_o,
  output logic [COL_W-1:0]  col_idx_o,
  output logic [2:0]        state_o
);

  localparam int PH_W  = $clog2(SLOT_LEN);
  localparam int CNT_W = 16;
  localparam int DRN_W = $clog2(DRAIN_SLOTS + 1);

  if (longint'(IMG_H) * longint'(WPR) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $fatal(1, "sobel_frame_sequencer: IMG_H*WPR exceeds the ADDR_W address space");
  end
  if (!phases_ok(PH_POP, PH_SHIFT, PH_HOLD, PH_MULT, PH_MAG, PH_OUT, SLOT_LEN)) begin : g_ph_chk
    $fatal(1, "sobel_frame_sequencer: stage phases must be distinct and below SLOT_LEN");
  end
  if (SLOT_LEN < 7 || DRAIN_SLOTS < 1 || PIX_PER_WORD * 8 > SOBEL_WORD_W ||
      IMG_W % PIX_PER_WORD != 0) begin : g_geo_chk
    $fatal(1, "sobel_frame_sequencer: illegal slot or geometry parameters");
  end

  seq_state_e        state_q, state_d, ret_q, ret_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              skip_q, skip_d, pf_done_q, pf_done_d;
  logic [PH_W-1:0]   phase;
  logic [CNT_W-1:0]  slot_cnt;
  logic              fill_done, at_pop, at_out, slot_end, in_run, stepping;
  int                row_nxt;

  assign at_pop    = (phase == PH_W'(PH_POP));
  assign at_out    = (phase == PH_W'(PH_OUT));
  assign slot_end  = (phase == PH_W'(SLOT_LEN - 1));
  assign fill_done = (slot_cnt >= CNT_W'(FILL_SLOTS));
  assign in_run    = (state_q == ST_RUN);
  assign row_nxt   = int'(row_q) + (skip_q ? 2 : 1);
  // The phase only moves while the frame stays active, so the first RUN cycle sits at phase 0.
  assign stepping  = (state_q inside {ST_RUN, ST_DRAIN, ST_STALL}) &&
                     (state_d inside {ST_RUN, ST_DRAIN});

  sobel_slot_timer #(
    .SLOT_LEN (SLOT_LEN),
    .PH_W     (PH_W),
    .CNT_W    (CNT_W)
  ) u_slot_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (state_d == ST_IDLE),
    .step_i     (stepping),
    .phase_o    (phase),
    .slot_cnt_o (slot_cnt)
  );

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    skip_d       = skip_q;
    pf_done_d    = pf_done_q;
    rd_en_o      = 1'b0;
    pop_en_o     = 1'b0;
    shift_en_o   = 1'b0;
    hold_en_o    = 1'b0;
    mult_en_o    = 1'b0;
    magdir_en_o  = 1'b0;
    out_en_o     = 1'b0;
    get_next_o   = 1'b0;
    frame_done_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_en_i) begin
          state_d   = ST_RUN;
          skip_d    = skip_rows_i;
          pf_done_d = 1'b0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        rd_en_o     = in_run && at_pop;
        pop_en_o    = in_run && at_pop;
        shift_en_o  = (phase == PH_W'(PH_SHIFT));
        hold_en_o   = (phase == PH_W'(PH_HOLD));
        mult_en_o   = (phase == PH_W'(PH_MULT));
        magdir_en_o = (phase == PH_W'(PH_MAG));
        out_en_o    = at_out && fill_done && out_ready_i;
        if (in_run && at_pop && !pf_done_q && int'(row_q) >= PREFETCH_ROW) begin
          get_next_o = 1'b1;
          pf_done_d  = 1'b1;
        end
        if (at_out && fill_done && !out_ready_i) begin
          state_d = ST_STALL;
          ret_d   = state_q;
        end else if (slot_end && in_run) begin
          if (col_q != COL_W'(WPR - 1)) begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else if (row_nxt >= IMG_H) begin
            state_d = ST_DRAIN;
          end else begin
            col_d  = '0;
            row_d  = ROW_W'(row_nxt);
            addr_d = ADDR_W'(row_nxt) * ADDR_W'(WPR);
          end
        end else if (slot_end) begin
          if (drain_q == DRN_W'(DRAIN_SLOTS - 1)) state_d = ST_DONE;
          else drain_d = drain_q + DRN_W'(1);
        end
      end
      ST_STALL: begin
        if (out_ready_i) begin
          out_en_o = 1'b1;
          state_d  = ret_q;
        end
      end
      ST_DONE: begin
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i && state_q != ST_IDLE) begin
      state_d      = ST_IDLE;
      frame_done_o = 1'b0;
    end
    if (state_d == ST_IDLE) begin
      row_d   = '0;
      col_d   = '0;
      addr_d  = '0;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      drain_q   <= '0;
      skip_q    <= 1'b0;
      pf_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      skip_q    <= skip_d;
      pf_done_q <= pf_done_d;
    end
  end

  assign rd_addr_o = addr_q;
  assign row_idx_o = row_q;
  assign col_idx_o = col_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer on a 32x4 image (4 words per row, 8-cycle slots).
module tb_sobel_frame_sequencer;

  localparam int ADDR_W = 20;

  logic clk;
  logic reset_n;
  logic start_en, skip_rows, out_ready, abort;

  logic              rd_en, pop_en, shift_en, hold_en, mult_en, magdir_en, out_en;
  logic              get_next, busy, frame_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        row_idx, col_idx;
  logic [2:0]        state;

  logic              rd_en2, pop_en2, shift_en2, hold_en2, mult_en2, magdir_en2, out_en2;
  logic              get_next2, busy2, frame_done2;
  logic [ADDR_W-1:0] rd_addr2;
  logic [1:0]        row_idx2, col_idx2;
  logic [2:0]        state2;

  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];

  int r_pop, r_popen, r_out, r_gn, r_gn2, r_gn_addr, r_gn_pop;
  int r_done, r_idle, r_idle_en, r_idle_state;
  int r_stall_bad, r_stall_state, r_stall_exit;

  sobel_frame_sequencer #(
    .IMG_W(32), .IMG_H(4), .PIX_PER_WORD(8), .ADDR_W(ADDR_W), .SLOT_LEN(8),
    .FILL_SLOTS(2), .DRAIN_SLOTS(2), .PREFETCH_ROW(2)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_en_i(start_en), .skip_rows_i(skip_rows),
    .out_ready_i(out_ready), .abort_i(abort), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .pop_en_o(pop_en), .shift_en_o(shift_en), .hold_en_o(hold_en), .mult_en_o(mult_en),
    .magdir_en_o(magdir_en), .out_en_o(out_en), .get_next_o(get_next), .busy_o(busy),
    .frame_done_o(frame_done), .row_idx_o(row_idx), .col_idx_o(col_idx), .state_o(state)
  );

  sobel_frame_sequencer #(
    .IMG_W(32), .IMG_H(4), .PIX_PER_WORD(8), .ADDR_W(ADDR_W), .SLOT_LEN(8),
    .FILL_SLOTS(2), .DRAIN_SLOTS(2), .PREFETCH_ROW(4)
  ) dut_nopf (
    .clk_i(clk), .reset_ni(reset_n), .start_en_i(start_en), .skip_rows_i(skip_rows),
    .out_ready_i(out_ready), .abort_i(abort), .rd_en_o(rd_en2), .rd_addr_o(rd_addr2),
    .pop_en_o(pop_en2), .shift_en_o(shift_en2), .hold_en_o(hold_en2), .mult_en_o(mult_en2),
    .magdir_en_o(magdir_en2), .out_en_o(out_en2), .get_next_o(get_next2), .busy_o(busy2),
    .frame_done_o(frame_done2), .row_idx_o(row_idx2), .col_idx_o(col_idx2), .state_o(state2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic any_en();
    return rd_en | pop_en | shift_en | hold_en | mult_en | magdir_en | out_en | get_next;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_exp(input logic skip);
    exp_q.delete();
    for (int r = 0; r < 4; r += (skip ? 2 : 1))
      for (int c = 0; c < 4; c++) exp_q.push_back(ADDR_W'(r * 4 + c));
  endtask

  // Starts a frame (start sampled at the next edge, so the first RUN cycle is k=1)
  // and observes it cycle by cycle on the falling edge.
  task automatic run_frame(input logic skip, input int stall_at, input int stall_len,
                           input int abort_at, input int reset_at, input logic start_abort);
    r_pop = 0; r_popen = 0; r_out = 0; r_gn = 0; r_gn2 = 0; r_gn_addr = -1; r_gn_pop = 0;
    r_done = -1; r_idle = -1; r_idle_en = -1; r_idle_state = -1;
    r_stall_bad = 0; r_stall_state = -1; r_stall_exit = -1;
    @(posedge clk); #1;
    start_en = 1'b1; skip_rows = skip; abort = start_abort; out_ready = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      start_en  = 1'b0;
      abort     = (k == abort_at);
      out_ready = !(k >= stall_at && k < stall_at + stall_len);
      @(negedge clk);
      if (rd_en) begin
        r_pop++;
        if (exp_q.size() > 0) check_val("rd_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
        else check_val("rd_addr_extra", 32'(rd_addr), 32'hFFFF_FFFF);
      end
      if (pop_en) r_popen++;
      if (out_en) r_out++;
      if (get_next) begin r_gn++; r_gn_addr = int'(rd_addr); r_gn_pop = int'(rd_en); end
      if (get_next2) r_gn2++;
      if (frame_done && r_done < 0) r_done = k;
      if (k >= stall_at && k < stall_at + stall_len && any_en()) r_stall_bad++;
      if (k == stall_at + 1) r_stall_state = int'(state);
      if (k == stall_at + stall_len) r_stall_exit = int'(out_en);
      if (k == reset_at) begin
        #1 reset_n = 1'b0;
        #1;
        check_val("async_rst_busy", 32'(busy), 0);
        check_val("async_rst_addr", 32'(rd_addr), 0);
        check_val("async_rst_state", 32'(state), 0);
        check_val("async_rst_misc", {26'd0, row_idx, col_idx, frame_done, any_en()}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        r_idle = k;
        break;
      end
      if (!busy) begin
        r_idle = k; r_idle_en = int'(any_en()); r_idle_state = int'(state);
        break;
      end
    end
    out_ready = 1'b1;
    abort = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start_en = 1'b0; skip_rows = 1'b0; out_ready = 1'b1; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_addr", 32'(rd_addr), 0);
    check_val("reset_enables", {30'd0, any_en(), frame_done}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("idle_state", 32'(state), 0);

    // 1: full frame, plus prefetch at row 2 on dut, none on dut_nopf
    load_exp(1'b0);
    run_frame(1'b0, 0, 0, 0, 0, 1'b0);
    check_val("f1_pops", r_pop, 16);
    check_val("f1_pop_en", r_popen, 16);
    check_val("f1_out_en", r_out, 16);
    check_val("f1_done_cyc", r_done, 145);
    check_val("f1_idle_cyc", r_idle, 146);
    check_val("f1_idle_enables", r_idle_en, 0);
    check_val("f1_exp_left", exp_q.size(), 0);
    check_val("pf_count", r_gn, 1);
    check_val("pf_addr", r_gn_addr, 8);
    check_val("pf_with_pop", r_gn_pop, 1);
    check_val("pf_row4_count", r_gn2, 0);

    // 2: row skip
    load_exp(1'b1);
    run_frame(1'b1, 0, 0, 0, 0, 1'b0);
    check_val("f2_pops", r_pop, 8);
    check_val("f2_out_en", r_out, 8);
    check_val("f2_done_cyc", r_done, 81);
    check_val("f2_exp_left", exp_q.size(), 0);
    check_val("f2_pf_count", r_gn, 1);

    // 3: back-pressure at the 4th PH_OUT (k=31) for 5 cycles
    load_exp(1'b0);
    run_frame(1'b0, 31, 5, 0, 0, 1'b0);
    check_val("f3_stall_state", r_stall_state, 2);
    check_val("f3_stall_enables", r_stall_bad, 0);
    check_val("f3_stall_exit_out", r_stall_exit, 1);
    check_val("f3_out_en", r_out, 16);
    check_val("f3_pops", r_pop, 16);
    check_val("f3_done_cyc", r_done, 150);

    // 5: abort in cycle 40
    load_exp(1'b0);
    run_frame(1'b0, 0, 0, 40, 0, 1'b0);
    check_val("f5_idle_cyc", r_idle, 41);
    check_val("f5_idle_state", r_idle_state, 0);
    check_val("f5_idle_enables", r_idle_en, 0);
    check_val("f5_no_done", r_done, -1);
    check_val("f5_pops", r_pop, 5);

    // restart after abort; abort coincident with start in IDLE is ignored
    load_exp(1'b0);
    run_frame(1'b0, 0, 0, 0, 0, 1'b1);
    check_val("f5r_pops", r_pop, 16);
    check_val("f5r_done_cyc", r_done, 145);
    check_val("f5r_exp_left", exp_q.size(), 0);

    // 6: asynchronous reset mid-DRAIN, then a clean frame
    load_exp(1'b0);
    run_frame(1'b0, 0, 0, 0, 135, 1'b0);
    check_val("f6_pops_before_rst", r_pop, 16);
    check_val("f6_no_done", r_done, -1);
    load_exp(1'b0);
    run_frame(1'b0, 0, 0, 0, 0, 1'b0);
    check_val("f6r_pops", r_pop, 16);
    check_val("f6r_done_cyc", r_done, 145);
    check_val("f6r_exp_left", exp_q.size(), 0);
    check_val("f6r_pf_count", r_gn, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
